// File: rtl/br_update_unit_if.sv
// Bus between the fetch/EX pipeline and the branch update unit: fetch-side
// allocation, EX resolution and the registered PHT update port.
interface br_update_unit_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int DEPTH       = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   fetch_valid_i;
    logic                   fetch_is_br_i;
    logic [31:0]            fetch_pc_i;
    logic [INDEX_WIDTH-1:0] rd_index_o;
    logic                   pred_taken_i;
    logic                   alloc_ready_o;
    logic                   resolve_valid_i;
    logic                   resolve_taken_i;
    logic                   flush_i;
    logic                   update_en_o;
    logic [INDEX_WIDTH-1:0] update_index_o;
    logic                   br_taken_o;
    logic                   mispredict_o;
    logic [INDEX_WIDTH-1:0] spec_ghr_o;
    logic [CNT_W-1:0]       count_o;

    modport master (
        output fetch_valid_i, fetch_is_br_i, fetch_pc_i, pred_taken_i,
        output resolve_valid_i, resolve_taken_i, flush_i,
        input  rd_index_o, alloc_ready_o, update_en_o, update_index_o,
        input  br_taken_o, mispredict_o, spec_ghr_o, count_o
    );

    modport slave (
        input  fetch_valid_i, fetch_is_br_i, fetch_pc_i, pred_taken_i,
        input  resolve_valid_i, resolve_taken_i, flush_i,
        output rd_index_o, alloc_ready_o, update_en_o, update_index_o,
        output br_taken_o, mispredict_o, spec_ghr_o, count_o
    );
endinterface

// File: rtl/br_update_unit.sv
// gshare PHT controller: read index generation, in-order in-flight branch
// queue, speculative/architectural GHRs and registered PHT update port.
module br_update_unit #(
    parameter int INDEX_WIDTH = 8,
    parameter int DEPTH       = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    br_update_unit_if.slave bus
);
    localparam int W     = INDEX_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry = {index, predicted taken}
    logic [W:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_spec_ghr;
    logic [W-1:0]     r_arch_ghr;

    logic             r_upd_vld_p1;
    logic [W-1:0]     r_upd_idx_p1;
    logic             r_upd_taken_p1;
    logic             r_mispredict_p1;

    logic [W-1:0]     w_rd_index;
    logic             w_alloc_ready;
    logic             w_alloc;
    logic             w_resolve;
    logic [W-1:0]     w_head_idx;
    logic             w_head_pred;
    logic             w_mispredict;
    logic             w_clear;
    logic             w_push;
    logic [W-1:0]     w_arch_next;
    logic [W-1:0]     w_spec_next;
    logic             w_pc_unused;

    assign w_pc_unused   = ^{bus.fetch_pc_i[31:W+2], bus.fetch_pc_i[1:0]};

    assign w_rd_index    = bus.fetch_pc_i[W+1:2] ^ r_spec_ghr;
    assign w_alloc_ready = (r_count < CNT_W'(DEPTH));
    assign w_alloc       = bus.fetch_valid_i & bus.fetch_is_br_i & w_alloc_ready;
    assign w_resolve     = bus.resolve_valid_i & (r_count != '0);
    assign w_head_idx    = r_mem[r_head][W:1];
    assign w_head_pred   = r_mem[r_head][0];
    assign w_mispredict  = w_resolve & (w_head_pred != bus.resolve_taken_i);
    // A mispredict or flush discards every younger entry, including a same-cycle alloc
    assign w_clear       = w_mispredict | bus.flush_i;
    assign w_push        = w_alloc & ~w_clear;

    always_comb begin
        w_arch_next = r_arch_ghr;
        if (w_resolve) begin
            w_arch_next = {r_arch_ghr[W-2:0], bus.resolve_taken_i};
        end
        w_spec_next = r_spec_ghr;
        if (w_clear) begin
            w_spec_next = w_arch_next;
        end else if (w_push) begin
            w_spec_next = {r_spec_ghr[W-2:0], bus.pred_taken_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_spec_ghr <= '0;
            r_arch_ghr <= '0;
        end else begin
            r_spec_ghr <= w_spec_next;
            r_arch_ghr <= w_arch_next;
            if (w_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + PTR_W'(w_resolve);
                r_tail  <= r_tail + PTR_W'(w_push);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_resolve);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_tail] <= {w_rd_index, bus.pred_taken_i};
        end
    end

    // p1: registered PHT update, one cycle after resolve
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd_vld_p1    <= 1'b0;
            r_upd_idx_p1    <= '0;
            r_upd_taken_p1  <= 1'b0;
            r_mispredict_p1 <= 1'b0;
        end else begin
            r_upd_vld_p1    <= w_resolve;
            r_mispredict_p1 <= w_mispredict;
            if (w_resolve) begin
                r_upd_idx_p1   <= w_head_idx;
                r_upd_taken_p1 <= bus.resolve_taken_i;
            end
        end
    end

    assign bus.rd_index_o     = w_rd_index;
    assign bus.alloc_ready_o  = w_alloc_ready;
    assign bus.update_en_o    = r_upd_vld_p1;
    assign bus.update_index_o = r_upd_idx_p1;
    assign bus.br_taken_o     = r_upd_taken_p1;
    assign bus.mispredict_o   = r_mispredict_p1;
    assign bus.spec_ghr_o     = r_spec_ghr;
    assign bus.count_o        = r_count;
endmodule
